mux_2in_16bits: RTL and testbench
=================================

Name: mux_2in_16bits

Overview:
- Two-input, WIDTH-bit word selector for the MIPS datapath: routes operand `a` or `b` to the result under `select`.
- The combinational result `r` is always live and needs no clock.
- A registered copy with a valid flag and a select-toggle counter supports pipelined consumers and debug.

Parameters:
- WIDTH, 16, data width of a, b, r, r_q.
- CNT_W, 8, width of the saturating select-toggle counter.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand routed when select=0.
- b  input  WIDTH  operand routed when select=1.
- select  input  1  0 selects a, 1 selects b.
- hold  input  1  1 freezes r_q, r_valid and the toggle-tracking register.
- r  output  WIDTH  combinational result.
- r_q  output  WIDTH  registered result.
- r_valid  output  1  r_q holds a captured value.
- eq  output  1  combinational, 1 when a == b.
- sel_toggles  output  CNT_W  saturating count of sampled select changes.

Behaviour:
- r = select ? b : a, purely combinational, with zero clock latency.
  - r is unaffected by clk, rst_n and hold.
  - r settles within the same delta/timestep as its inputs.
- eq = (a == b), combinational.
- While rst_n=0, asynchronously:
  - r_q = 0, r_valid = 0, sel_toggles = 0.
  - Internal sel_prev = 0.
- At each rising clk with rst_n=1 and hold=0:
  - r_q <= r (one-cycle latency), r_valid <= 1, sel_prev <= select.
  - If select != sel_prev, sel_toggles increments.
  - sel_toggles saturates at 2^CNT_W-1 and never wraps.
- At a rising clk with hold=1, all registers keep their value.
  - hold is ignored during reset; reset wins.
- Deassertion of rst_n is synchronised to clk by the consumer; the block takes no action at deassertion itself.
- Reset mid-operation clears r_q, r_valid and sel_toggles immediately. r keeps tracking the inputs.
- The first capture after reset with select=1 counts as one toggle, because sel_prev resets to 0.
- The width rule is bitwise, with no sign extension or arithmetic.
- Any value of WIDTH >= 1 is legal.

Optional Feature:
- Macro: MUX2IN16_PARITY_EN.
- When defined:
  - Adds output r_par (1 bit, combinational) = XOR-reduction of r, i.e. even parity.
  - Adds output r_q_par (1 bit, registered): reset 0, captured alongside r_q, obeys hold.
- When undefined:
  - Neither port exists and no parity logic is generated.
  - All other behaviour is identical.

Test Plan:
- a=16'h0239, b=16'h00e3, select=0, wait 10 time units without clocking -> r=16'h0239, eq=0.
- Same operands, select=1, wait 10 -> r=16'h00e3. The combinational path must not depend on clk or reset state.
- rst_n=0 with any inputs -> r_q=0, r_valid=0, sel_toggles=0 immediately; r still equals the selected input.
  - Release reset, select=0, one clk -> r_q=16'h0239, r_valid=1, sel_toggles=0.
- Alternate select 0,1,0,1 on successive clks with hold=0 -> r_q follows r one cycle late, sel_toggles=4.
  - With CNT_W=2 and 5 toggles -> sel_toggles saturates at 3.
- hold=1, change select and operands for 3 clks -> r_q, r_valid, sel_toggles unchanged while r updates combinationally.
  - Assert rst_n=0 mid-hold -> all registers clear at once.
- a=b=16'hFFFF -> eq=1, r=16'hFFFF for either select.
  - With MUX2IN16_PARITY_EN defined, r=16'h0239 -> r_par=1; r=16'h00e3 -> r_par=1; r=16'h0003 -> r_par=0.

Source files
------------

// File: rtl/mux_2in_16bits.sv
// mux_2in_16bits: two-input WIDTH-bit word selector with a registered copy,
// a valid flag and a saturating count of sampled select changes.
// Optional macro MUX2IN16_PARITY_EN adds combinational and registered
// even-parity outputs (r_par, r_q_par).
module mux_2in_16bits #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    input  logic             hold,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_q,
    output logic             r_valid,
    output logic             eq,
    output logic [CNT_W-1:0] sel_toggles
`ifdef MUX2IN16_PARITY_EN
    ,
    output logic             r_par,
    output logic             r_q_par
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic sel_prev;
    logic toggle_c;
    logic cnt_sat_c;

    // Live selection and operand-equality flag, independent of clock and reset
    always_comb begin
        r  = select ? b : a;
        eq = (a == b);
    end

    // A change against the last sampled select is counted unless saturated
    always_comb begin
        toggle_c  = (select != sel_prev);
        cnt_sat_c = (sel_toggles == CNT_MAX);
    end

    // Registered copy, valid flag and toggle tracking; hold freezes all of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_valid     <= 1'b0;
            sel_prev    <= 1'b0;
            sel_toggles <= '0;
        end else if (!hold) begin
            r_q      <= r;
            r_valid  <= 1'b1;
            sel_prev <= select;
            if (toggle_c && !cnt_sat_c) begin
                sel_toggles <= sel_toggles + CNT_W'(1);
            end
        end
    end

`ifdef MUX2IN16_PARITY_EN
    // Even parity of the live result
    always_comb begin
        r_par = ^r;
    end

    // Parity captured alongside r_q under the same hold/reset rules
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_par <= 1'b0;
        end else if (!hold) begin
            r_q_par <= ^r;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2in_16bits.sv
// Bench for mux_2in_16bits: directed plan steps followed by randomized
// traffic, all compared against a behavioural model kept in this file.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_mux_2in_16bits;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        select;
    logic        hold;

    logic [15:0] r;
    logic [15:0] r_q;
    logic        r_valid;
    logic        eq;
    logic [7:0]  sel_toggles;

    logic [15:0] r2;
    logic [15:0] r_q2;
    logic        r_valid2;
    logic        eq2;
    logic [1:0]  sel_toggles2;

`ifdef MUX2IN16_PARITY_EN
    logic r_par, r_q_par, r_par2, r_q_par2;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural reference state
    logic [15:0] m_rq;
    logic        m_valid;
    logic        m_prev;
    int          m_cnt;
    int          m_cnt2;
    logic        m_qpar;

    mux_2in_16bits #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .select(select), .hold(hold),
        .r(r), .r_q(r_q), .r_valid(r_valid), .eq(eq), .sel_toggles(sel_toggles)
`ifdef MUX2IN16_PARITY_EN
        , .r_par(r_par), .r_q_par(r_q_par)
`endif
    );

    mux_2in_16bits #(.WIDTH(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .select(select), .hold(hold),
        .r(r2), .r_q(r_q2), .r_valid(r_valid2), .eq(eq2), .sel_toggles(sel_toggles2)
`ifdef MUX2IN16_PARITY_EN
        , .r_par(r_par2), .r_q_par(r_q_par2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = clk_en ? ~clk : clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic parity16(input logic [15:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    function automatic logic [15:0] pick(input logic s, input logic [15:0] x, input logic [15:0] y);
        return s ? y : x;
    endfunction

    task automatic model_reset();
        m_rq    = '0;
        m_valid = 1'b0;
        m_prev  = 1'b0;
        m_cnt   = 0;
        m_cnt2  = 0;
        m_qpar  = 1'b0;
    endtask

    // what one rising edge should do, from the behavioural rules
    task automatic model_clock();
        if (rst_n && !hold) begin
            m_rq    = pick(select, a, b);
            m_qpar  = parity16(m_rq);
            m_valid = 1'b1;
            if (select != m_prev) begin
                m_cnt  = (m_cnt  + 1 > 255) ? 255 : m_cnt + 1;
                m_cnt2 = (m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1;
            end
            m_prev = select;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".r"},       32'(r),            32'(pick(select, a, b)));
        check({tag, ".eq"},      32'(eq),           32'(a == b));
        check({tag, ".r_q"},     32'(r_q),          32'(m_rq));
        check({tag, ".valid"},   32'(r_valid),      32'(m_valid));
        check({tag, ".tog"},     32'(sel_toggles),  32'(m_cnt));
        check({tag, ".tog_sat"}, 32'(sel_toggles2), 32'(m_cnt2));
        check({tag, ".r_q_sat"}, 32'(r_q2),         32'(m_rq));
`ifdef MUX2IN16_PARITY_EN
        check({tag, ".r_par"},   32'(r_par),        32'(parity16(pick(select, a, b))));
        check({tag, ".r_q_par"}, 32'(r_q_par),      32'(m_qpar));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [15:0] na, input logic [15:0] nb,
                         input logic ns, input logic nh);
        @(negedge clk);
        a = na; b = nb; select = ns; hold = nh;
    endtask

    initial begin
        clk_en = 1'b0;
        rst_n  = 1'b0;
        hold   = 1'b0;
        a      = 16'h0239;
        b      = 16'h00e3;
        select = 1'b0;
        model_reset();

        // combinational path with no clock running, registers held in reset
        #10;
        check("comb_sel0.r", 32'(r), 32'h0239);
        check("comb_sel0.eq", 32'(eq), 32'h0);
        select = 1'b1;
        #10;
        check("comb_sel1.r", 32'(r), 32'h00e3);
        check_all("in_reset");

        // release reset and capture a
        select = 1'b0;
        rst_n  = 1'b1;
        #2;
        clk_en = 1'b1;
        step("first_capture");
        check("first_capture.r_q_const", 32'(r_q), 32'h0239);
        check("first_capture.tog_const", 32'(sel_toggles), 32'h0);

        // alternating select: 4 toggles, saturating instance stops at 3
        drive(16'h0239, 16'h00e3, 1'b1, 1'b0); step("alt1");
        drive(16'h0239, 16'h00e3, 1'b0, 1'b0); step("alt2");
        drive(16'h0239, 16'h00e3, 1'b1, 1'b0); step("alt3");
        drive(16'h0239, 16'h00e3, 1'b0, 1'b0); step("alt4");
        check("alt4.tog_const", 32'(sel_toggles), 32'd4);
        check("alt4.sat_const", 32'(sel_toggles2), 32'd3);
        drive(16'h0239, 16'h00e3, 1'b1, 1'b0); step("alt5");
        check("alt5.sat_const", 32'(sel_toggles2), 32'd3);

        // hold freezes registers while r follows the inputs
        for (int i = 0; i < 3; i++) begin
            drive(16'($urandom), 16'($urandom), 1'(i % 2), 1'b1);
            step("hold");
        end
        check("hold.tog_const", 32'(sel_toggles), 32'd5);

        // reset asserted mid-hold clears at once
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;

        // equal operands
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0); #1;
        check("eq_sel0.eq", 32'(eq), 32'h1);
        check("eq_sel0.r", 32'(r), 32'hFFFF);
        step("eq_sel0");
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0); #1;
        check("eq_sel1.eq", 32'(eq), 32'h1);
        check("eq_sel1.r", 32'(r), 32'hFFFF);
        step("eq_sel1");

`ifdef MUX2IN16_PARITY_EN
        drive(16'h0239, 16'h00e3, 1'b0, 1'b0); #1;
        check("par_0239", 32'(r_par), 32'h1);
        select = 1'b1; #1;
        check("par_00e3", 32'(r_par), 32'h1);
        a = 16'h0003; select = 1'b0; #1;
        check("par_0003", 32'(r_par), 32'h0);
        step("par_capture");
`endif

        // randomized traffic with occasional hold and async reset pulses
        for (int i = 0; i < 60; i++) begin
            drive(16'($urandom), ($urandom_range(0, 7) == 0) ? a : 16'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0);
            if (b == a) b = a;
            #1;
            check("rand_comb.r", 32'(r), 32'(pick(select, a, b)));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rand_reset");
                rst_n = 1'b1;
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
